reg_to_axi_bridge: RTL and testbench

Register-bus requester to AXI manager bridge. It converts single reg_req_t accesses into single-beat AXI4 transactions and returns the AXI result as a reg_rsp_t. It is the reverse of the peripheral-bus AXI-to-reg path. It lets reg-only initiators (debug/config agents) drive a crossbar slave port using core_v_mcu_pkg::axi_mst_req_t/axi_mst_rsp_t. One transaction is outstanding at a time.

---
 rtl/core_v_mcu_pkg.sv | 87 ++++++++
 rtl/reg_to_axi_bridge.sv | 128 ++++++++++++
 tb/tb_reg_to_axi_bridge.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/core_v_mcu_pkg.sv
// core_v_mcu_pkg: shared reg-bus and AXI manager channel types plus AXI attribute constants
package core_v_mcu_pkg;
  localparam int unsigned AXI_ADDR_WIDTH = 64;
  localparam int unsigned AXI_DATA_WIDTH = 64;
  localparam int unsigned AXI_ID_WIDTH = 4;
  localparam int unsigned AXI_USER_WIDTH = 1;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef struct packed {
    addr_t addr;
    logic write;
    logic [REG_DATA_WIDTH-1:0] wdata;
    logic [REG_DATA_WIDTH/8-1:0] wstrb;
    logic valid;
  } reg_req_t;
  typedef struct packed {
    logic [REG_DATA_WIDTH-1:0] rdata;
    logic error;
    logic ready;
  } reg_rsp_t;
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    addr_t addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    logic [AXI_USER_WIDTH-1:0] user;
  } aw_chan_t;
  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_DATA_WIDTH/8-1:0] strb;
    logic last;
    logic [AXI_USER_WIDTH-1:0] user;
  } w_chan_t;
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0] resp;
    logic [AXI_USER_WIDTH-1:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    addr_t addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [AXI_USER_WIDTH-1:0] user;
  } ar_chan_t;
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0] resp;
    logic last;
    logic [AXI_USER_WIDTH-1:0] user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic aw_valid;
    w_chan_t w;
    logic w_valid;
    logic b_ready;
    ar_chan_t ar;
    logic ar_valid;
    logic r_ready;
  } axi_mst_req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    b_chan_t b;
    logic r_valid;
    r_chan_t r;
  } axi_mst_rsp_t;
endpackage

// File: rtl/reg_to_axi_bridge.sv
// reg_to_axi_bridge: turns single reg-bus accesses into single-beat AXI4 transactions, one outstanding
module reg_to_axi_bridge
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = AXI_ADDR_WIDTH,
  parameter int unsigned AxiDataWidth = AXI_DATA_WIDTH,
  parameter int unsigned AxiIdWidth = AXI_ID_WIDTH,
  parameter int unsigned AxiUserWidth = AXI_USER_WIDTH,
  parameter int unsigned RegDataWidth = REG_DATA_WIDTH,
  parameter logic [AxiIdWidth-1:0] AxiId = '0,
  parameter type reg_req_t = core_v_mcu_pkg::reg_req_t,
  parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t,
  parameter type axi_req_t = core_v_mcu_pkg::axi_mst_req_t,
  parameter type axi_rsp_t = core_v_mcu_pkg::axi_mst_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output axi_req_t axi_req_o,
  input  axi_rsp_t axi_rsp_i,
  output logic     busy_o
);
  localparam int unsigned NumLanes = AxiDataWidth / RegDataWidth;
  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  if (AxiDataWidth % 32 != 0 || AxiDataWidth < RegDataWidth || RegDataWidth != 32 || AxiUserWidth == 0)
    begin : g_bad_width
      $error("reg_to_axi_bridge: unsupported width parameters");
    end
  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_e;
  state_e state, state_nxt;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [RegDataWidth-1:0] wdata_q, rdata_q;
  logic [RegDataWidth/8-1:0] wstrb_q;
  logic aw_done, w_done, error_q;
  int unsigned lane;
  logic unused_rsp;
  function automatic int unsigned lane_of(input logic [AxiAddrWidth-1:0] a);
    return 32'(a >> 2) % NumLanes;
  endfunction
  assign lane = lane_of(addr_q);
  assign busy_o = state != IDLE;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0], axi_rsp_i.r.id,
                        axi_rsp_i.r.last, axi_rsp_i.r.user, axi_rsp_i.r.resp[0]};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && reg_req_i.valid) begin
        addr_q <= reg_req_i.addr;
        wdata_q <= reg_req_i.wdata;
        wstrb_q <= reg_req_i.wstrb;
        rdata_q <= '0;
        error_q <= 1'b0;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (state == WRITE) begin
        aw_done <= aw_done | axi_rsp_i.aw_ready;
        w_done <= w_done | axi_rsp_i.w_ready;
      end
      if (state == WAIT_B && axi_rsp_i.b_valid) error_q <= axi_rsp_i.b.resp[1];
      if (state == WAIT_R && axi_rsp_i.r_valid) begin
        rdata_q <= RegDataWidth'(axi_rsp_i.r.data >> (RegDataWidth * lane));
        error_q <= axi_rsp_i.r.resp[1];
      end
    end
  end
  always_comb begin
    state_nxt = state;
    reg_rsp_o = '0;
    axi_req_o = '0;
    axi_req_o.aw.id = AxiId;
    axi_req_o.aw.addr = addr_q;
    axi_req_o.aw.size = AXI_SIZE_4B;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.ar.id = AxiId;
    axi_req_o.ar.addr = addr_q;
    axi_req_o.ar.size = AXI_SIZE_4B;
    axi_req_o.ar.burst = AXI_BURST_INCR;
    axi_req_o.w.data = {NumLanes{wdata_q}};
    axi_req_o.w.strb = StrbWidth'(wstrb_q) << ((RegDataWidth / 8) * lane);
    axi_req_o.w.last = 1'b1;
    unique case (state)
      IDLE: state_nxt = !reg_req_i.valid ? IDLE : reg_req_i.write ? WRITE : READ;
      WRITE: begin
        axi_req_o.aw_valid = !aw_done;
        axi_req_o.w_valid = !w_done;
        state_nxt = ((aw_done || axi_rsp_i.aw_ready) && (w_done || axi_rsp_i.w_ready)) ? WAIT_B : WRITE;
      end
      WAIT_B: begin
        axi_req_o.b_ready = 1'b1;
        state_nxt = axi_rsp_i.b_valid ? RESP : WAIT_B;
      end
      READ: begin
        axi_req_o.ar_valid = 1'b1;
        state_nxt = axi_rsp_i.ar_ready ? WAIT_R : READ;
      end
      WAIT_R: begin
        axi_req_o.r_ready = 1'b1;
        state_nxt = axi_rsp_i.r_valid ? RESP : WAIT_R;
      end
      RESP: begin
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi_req_o.aw_valid && !axi_rsp_i.aw_ready |=> axi_req_o.aw_valid && $stable(axi_req_o.aw));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi_req_o.w_valid && !axi_rsp_i.w_ready |=> axi_req_o.w_valid && $stable(axi_req_o.w));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi_req_o.ar_valid && !axi_rsp_i.ar_ready |=> axi_req_o.ar_valid && $stable(axi_req_o.ar));
`endif
endmodule

// File: tb/tb_reg_to_axi_bridge.sv
// tb_reg_to_axi_bridge: directed plus randomized accesses against a timing/data model of the bridge
module tb_reg_to_axi_bridge;
  import core_v_mcu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  reg_req_t reg_req;
  reg_rsp_t reg_rsp;
  axi_mst_req_t axi_req;
  axi_mst_rsp_t axi_rsp;
  logic busy;
  int checks = 0;
  int failures = 0;

  reg_to_axi_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(reg_req), .reg_rsp_o(reg_rsp),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // d1/d2/d3: write = aw wait, w wait, b wait; read = ar wait, r wait (d3 unused)
  task automatic run_access(input logic wr, input logic [63:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int d1, input int d2, input int d3,
                            input logic [1:0] resp, input logic [63:0] rd64);
    logic [63:0] a;
    logic lane, exp_err;
    logic [31:0] exp_rd;
    logic [7:0] exp_strb;
    int m, bc, rc, lat;
    a = addr;
    lane = a[2];
    m = (d1 > d2) ? d1 : d2;
    bc = 2 + m + d3;
    rc = 2 + d1 + d2;
    lat = wr ? bc + 1 : rc + 1;
    exp_err = (resp == 2'b10) || (resp == 2'b11);
    exp_rd = lane ? rd64[63:32] : rd64[31:0];
    exp_strb = lane ? {wstrb, 4'h0} : {4'h0, wstrb};
    reg_req.addr = addr;
    reg_req.write = wr;
    reg_req.wdata = wdata;
    reg_req.wstrb = wstrb;
    reg_req.valid = 1'b1;
    axi_rsp = '0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      check("busy", 64'(busy), 64'(c <= lat));
      check("rsp_ready", 64'(reg_rsp.ready), 64'(c == lat));
      check("aw_valid", 64'(axi_req.aw_valid), 64'(wr && c <= 1 + d1));
      check("w_valid", 64'(axi_req.w_valid), 64'(wr && c <= 1 + d2));
      check("b_ready", 64'(axi_req.b_ready), 64'(wr && c >= 2 + m && c <= bc));
      check("ar_valid", 64'(axi_req.ar_valid), 64'(!wr && c <= 1 + d1));
      check("r_ready", 64'(axi_req.r_ready), 64'(!wr && c >= 2 + d1 && c <= rc));
      if (wr && c <= 1 + d1) begin
        check("aw_addr", axi_req.aw.addr, addr);
        check("aw_len_size_burst_id", {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.id},
              {8'd0, 3'd2, 2'b01, 4'd0});
      end
      if (wr && c <= 1 + d2) begin
        check("w_data", axi_req.w.data, {wdata, wdata});
        check("w_strb_last", {axi_req.w.strb, axi_req.w.last}, {exp_strb, 1'b1});
      end
      if (!wr && c <= 1 + d1) begin
        check("ar_addr", axi_req.ar.addr, addr);
        check("ar_len_size_burst_id", {axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.id},
              {8'd0, 3'd2, 2'b01, 4'd0});
      end
      if (c == lat) begin
        check("rsp_rdata", 64'(reg_rsp.rdata), wr ? 64'd0 : 64'(exp_rd));
        check("rsp_error", 64'(reg_rsp.error), 64'(exp_err));
      end
      axi_rsp = '0;
      axi_rsp.aw_ready = wr && c == 1 + d1;
      axi_rsp.w_ready = wr && c == 1 + d2;
      axi_rsp.b_valid = wr && c == bc;
      axi_rsp.b.resp = resp;
      axi_rsp.ar_ready = !wr && c == 1 + d1;
      axi_rsp.r_valid = !wr && c == rc;
      axi_rsp.r.data = rd64;
      axi_rsp.r.resp = resp;
      axi_rsp.r.last = 1'b1;
      reg_req.valid = c <= lat;
    end
  endtask

  initial begin
    reg_req = '0;
    axi_rsp = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}, '0);
    check("reset_rsp", {reg_rsp.ready, reg_rsp.error, reg_rsp.rdata}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_access(1'b1, 64'h0000_0000_0000_1004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, '0);
    run_access(1'b0, 64'h0000_0000_0000_2000, '0, '0, 0, 0, 0, 2'b00, 64'h1111_2222_3333_4444);
    run_access(1'b0, 64'h0000_0000_0000_2004, '0, '0, 0, 0, 0, 2'b00, 64'h1111_2222_3333_4444);
    run_access(1'b1, 64'h0000_0000_0000_3000, 32'hCAFE0001, 4'h3, 3, 0, 1, 2'b00, '0);
    run_access(1'b1, 64'h0000_0000_0000_3004, 32'hCAFE0002, 4'hC, 0, 3, 0, 2'b00, '0);
    run_access(1'b1, 64'h0000_0000_0000_3007, 32'hCAFE0003, 4'h5, 2, 2, 1, 2'b00, '0);
    run_access(1'b0, 64'h0000_0000_0000_4000, '0, '0, 0, 0, 0, 2'b11, 64'h5555_6666_7777_8888);
    run_access(1'b1, 64'h0000_0000_0000_4004, 32'h12345678, 4'hF, 0, 0, 0, 2'b10, '0);
    run_access(1'b0, 64'h0000_0000_0000_4004, '0, '0, 0, 0, 0, 2'b01, 64'h9999_AAAA_BBBB_CCCC);
    run_access(1'b1, 64'h0000_0000_0000_4000, 32'h87654321, 4'h1, 1, 0, 0, 2'b01, '0);
    run_access(1'b0, 64'h0000_0000_0000_5004, '0, '0, 5, 4, 0, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0);
    reg_req.addr = 64'h0000_0000_0000_6000;
    reg_req.write = 1'b1;
    reg_req.wdata = 32'h0BAD_F00D;
    reg_req.wstrb = 4'hF;
    reg_req.valid = 1'b1;
    axi_rsp = '0;
    @(posedge clk);
    #1;
    axi_rsp.aw_ready = 1'b1;
    axi_rsp.w_ready = 1'b1;
    @(posedge clk);
    #1;
    axi_rsp = '0;
    check("pre_reset_b_ready", 64'(axi_req.b_ready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}, '0);
    check("async_reset_busy_ready", {busy, reg_rsp.ready}, '0);
    reg_req.valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_access(1'b0, 64'h0000_0000_0000_7004, '0, '0, 1, 1, 0, 2'b00, 64'hFEED_FACE_0123_4567);
    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom), {$urandom, $urandom}, $urandom, 4'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 2'($urandom), {$urandom, $urandom});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
